// File: rtl/lif_param_sequencer.sv
// Configuration/run-control sequencer: serialises a host parameter frame onto the
// neuron system's load pins, waits for a qualified params_ready, then gates input_enable.
// Optional load timeout with sticky cfg_error is compiled in by defining LIF_SEQ_TIMEOUT_EN.
module lif_param_sequencer #(
  parameter int FRAME_W     = 26,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [FRAME_W-1:0] cfg_data,
  input  logic               run_req,
  input  logic               params_ready_in,
  output logic               load_mode,
  output logic               serial_data,
  output logic               input_enable,
  output logic               busy,
  output logic               cfg_error
);

  localparam int CNT_W = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

`ifdef LIF_SEQ_TIMEOUT_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_SHIFT, ST_WAIT_RDY, ST_RUN, ST_ERROR
  } state_t;

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_cfg_error;
`else
  typedef enum logic [1:0] {
    ST_IDLE, ST_SHIFT, ST_WAIT_RDY, ST_RUN
  } state_t;
`endif

  state_t             r_state;
  // The MSB goes straight to serial_data at accept, so only the remaining bits are held.
  logic [FRAME_W-2:0] r_shift;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic               r_seen_low;
  logic               r_cfg_ready;
  logic               r_load_mode;
  logic               r_serial;
  logic               r_input_enable;
  logic               r_busy;
  logic               w_accept;

  assign w_accept = cfg_valid & r_cfg_ready;

  // NOTE: every state element uses non-blocking assignment so all registers update
  // together from pre-edge values; blocking here would create ordering-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_shift        <= '0;
      r_bit_cnt      <= '0;
      r_seen_low     <= 1'b0;
      r_cfg_ready    <= 1'b0;
      r_load_mode    <= 1'b0;
      r_serial       <= 1'b0;
      r_input_enable <= 1'b0;
      r_busy         <= 1'b0;
`ifdef LIF_SEQ_TIMEOUT_EN
      r_to_cnt       <= '0;
      r_cfg_error    <= 1'b0;
`endif
    end else if (w_accept) begin
      // Accept from IDLE, RUN or ERROR; a frame beats a simultaneous run_req.
      r_state        <= ST_SHIFT;
      r_shift        <= cfg_data[FRAME_W-2:0];
      r_bit_cnt      <= '0;
      r_seen_low     <= 1'b0;
      r_cfg_ready    <= 1'b0;
      r_load_mode    <= 1'b1;
      r_serial       <= cfg_data[FRAME_W-1];
      r_input_enable <= 1'b0;
      r_busy         <= 1'b1;
`ifdef LIF_SEQ_TIMEOUT_EN
      r_cfg_error    <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cfg_ready <= 1'b1;
        end

        ST_SHIFT: begin
          if (!params_ready_in) r_seen_low <= 1'b1;
          if (r_bit_cnt == LAST_BIT) begin
            r_state     <= ST_WAIT_RDY;
            r_load_mode <= 1'b0;
            r_serial    <= 1'b0;
`ifdef LIF_SEQ_TIMEOUT_EN
            r_to_cnt    <= '0;
`endif
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            r_serial  <= r_shift[FRAME_W-2];
            r_shift   <= {r_shift[FRAME_W-3:0], 1'b0};
          end
        end

        ST_WAIT_RDY: begin
          if (!params_ready_in) r_seen_low <= 1'b1;
          // A high level only counts once the loader has been seen dropping it.
          if (params_ready_in && r_seen_low) begin
            r_state     <= ST_RUN;
            r_busy      <= 1'b0;
            r_cfg_ready <= 1'b1;
`ifdef LIF_SEQ_TIMEOUT_EN
          end else if (r_to_cnt >= TO_LAST) begin
            r_state     <= ST_ERROR;
            r_busy      <= 1'b0;
            r_cfg_ready <= 1'b1;
            r_cfg_error <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
`endif
          end
        end

        ST_RUN: begin
          r_input_enable <= run_req;
        end

`ifdef LIF_SEQ_TIMEOUT_EN
        ST_ERROR: begin
          r_input_enable <= 1'b0;
        end
`endif

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cfg_ready    = r_cfg_ready;
  assign load_mode    = r_load_mode;
  assign serial_data  = r_serial;
  assign input_enable = r_input_enable;
  assign busy         = r_busy;
`ifdef LIF_SEQ_TIMEOUT_EN
  assign cfg_error    = r_cfg_error;
`else
  assign cfg_error    = 1'b0;
`endif

endmodule

// File: tb/tb_lif_param_sequencer.sv
// Self-checking bench for lif_param_sequencer: serial bits and input_enable are
// predicted into scoreboard queues at stimulus time and popped when the DUT drives them.
module tb_lif_param_sequencer;

  localparam int FRAME_W     = 26;
  localparam int TIMEOUT_CYC = 64;

  logic               clk = 1'b0;
  logic               reset;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [FRAME_W-1:0] cfg_data;
  logic               run_req;
  logic               params_ready_in;
  logic               load_mode;
  logic               serial_data;
  logic               input_enable;
  logic               busy;
  logic               cfg_error;

  int n_checks = 0;
  int n_fail   = 0;
  logic exp_bit_q[$];
  logic exp_ie_q[$];

  lif_param_sequencer #(
    .FRAME_W    (FRAME_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_data       (cfg_data),
    .run_req        (run_req),
    .params_ready_in(params_ready_in),
    .load_mode      (load_mode),
    .serial_data    (serial_data),
    .input_enable   (input_enable),
    .busy           (busy),
    .cfg_error      (cfg_error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame for a single accept cycle, then scrambles cfg_data.
  task automatic send_frame(input logic [FRAME_W-1:0] f);
    cfg_valid = 1'b1;
    cfg_data  = f;
    for (int i = FRAME_W - 1; i >= 0; i--) exp_bit_q.push_back(f[i]);
    tick();
    cfg_valid = 1'b0;
    cfg_data  = FRAME_W'($urandom);
  endtask

  // Pops expected bits while load_mode is high; the loader drops ready during the load.
  task automatic check_shift(input bit drop_ready);
    int   n = 0;
    logic exp;
    while (load_mode === 1'b1 && n < FRAME_W + 4) begin
      if (drop_ready) params_ready_in = 1'b0;
      exp = (exp_bit_q.size() != 0) ? exp_bit_q.pop_front() : 1'bx;
      n_checks++;
      if (serial_data !== exp) begin
        n_fail++;
        $display("FAIL serial_bit[%0d]: got %b expected %b", n, serial_data, exp);
      end
      n++;
      tick();
    end
    n_checks++;
    if (n != FRAME_W) begin
      n_fail++;
      $display("FAIL load_mode_len: got %0d cycles expected %0d", n, FRAME_W);
    end
    n_checks++;
    if (exp_bit_q.size() != 0) begin
      n_fail++;
      $display("FAIL bits_left: got %0d unsent expected 0", exp_bit_q.size());
    end
    exp_bit_q.delete();
    n_checks++;
    if ({load_mode, serial_data, busy, cfg_ready} !== 4'b0010) begin
      n_fail++;
      $display("FAIL wait_rdy_outs: got lm/sd/busy/rdy=%b expected 0010",
               {load_mode, serial_data, busy, cfg_ready});
    end
  endtask

  // Loader model: ready returns 3 cycles after load_mode falls; RUN one edge later.
  task automatic loader_to_run();
    tick();
    tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL early_run: got busy=%b expected 1", busy);
    end
    tick();
    params_ready_in = 1'b1;
    tick();
    n_checks++;
    if ({busy, cfg_ready, input_enable} !== 3'b010) begin
      n_fail++;
      $display("FAIL run_entry: got busy/rdy/ie=%b expected 010",
               {busy, cfg_ready, input_enable});
    end
  endtask

  task automatic test_reset();
    reset           = 1'b0;
    cfg_valid       = 1'b0;
    cfg_data        = '0;
    run_req         = 1'b0;
    params_ready_in = 1'b1;
    #12;
    n_checks++;
    if ({cfg_ready, load_mode, serial_data, input_enable, busy, cfg_error} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outs: got %b expected 000000",
               {cfg_ready, load_mode, serial_data, input_enable, busy, cfg_error});
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    n_checks++;
    if ({cfg_ready, load_mode, busy, cfg_error} !== 4'b1000) begin
      n_fail++;
      $display("FAIL post_reset: got rdy/lm/busy/err=%b expected 1000",
               {cfg_ready, load_mode, busy, cfg_error});
    end
  endtask

  task automatic test_load_basic();
    send_frame(26'h2A5_C3F1);
    check_shift(1'b1);
    loader_to_run();
  endtask

  task automatic test_run_toggle();
    logic pat[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic exp;
    foreach (pat[i]) begin
      run_req = pat[i];
      exp_ie_q.push_back(pat[i]);
      tick();
      exp = exp_ie_q.pop_front();
      n_checks++;
      if (input_enable !== exp) begin
        n_fail++;
        $display("FAIL ie_toggle[%0d]: got %b expected %b", i, input_enable, exp);
      end
    end
    // Frame and run_req together: the frame wins and input_enable drops.
    run_req = 1'b1;
    send_frame(26'h155_AA55);
    run_req = 1'b0;
    n_checks++;
    if ({input_enable, load_mode} !== 2'b01) begin
      n_fail++;
      $display("FAIL frame_wins: got ie/lm=%b expected 01", {input_enable, load_mode});
    end
    check_shift(1'b1);
    loader_to_run();
  endtask

  task automatic test_stuck_ready();
    params_ready_in = 1'b1;
    send_frame(26'h3FF_0001);
    check_shift(1'b0);
    repeat (10) tick();
    n_checks++;
    if ({busy, cfg_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL stuck_ready: got busy/rdy=%b expected 10", {busy, cfg_ready});
    end
    params_ready_in = 1'b0;
    tick();
    params_ready_in = 1'b1;
    tick();
    n_checks++;
    if ({busy, cfg_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL stuck_release: got busy/rdy=%b expected 01", {busy, cfg_ready});
    end
  endtask

  task automatic test_timeout();
    send_frame(26'h0C3_5A5A);
    check_shift(1'b1);
`ifdef LIF_SEQ_TIMEOUT_EN
    begin
      int n = 0;
      while (cfg_error !== 1'b1 && n < TIMEOUT_CYC + 10) begin
        tick();
        n++;
      end
      n_checks++;
      if (n != TIMEOUT_CYC) begin
        n_fail++;
        $display("FAIL timeout_len: got %0d cycles expected %0d", n, TIMEOUT_CYC);
      end
      n_checks++;
      if ({cfg_ready, input_enable, busy} !== 3'b100) begin
        n_fail++;
        $display("FAIL error_outs: got rdy/ie/busy=%b expected 100",
                 {cfg_ready, input_enable, busy});
      end
      params_ready_in = 1'b1;
      send_frame(26'h2A5_C3F1);
      n_checks++;
      if ({cfg_error, load_mode} !== 2'b01) begin
        n_fail++;
        $display("FAIL error_clear: got err/lm=%b expected 01", {cfg_error, load_mode});
      end
      check_shift(1'b1);
      loader_to_run();
    end
`else
    repeat (100) tick();
    n_checks++;
    if ({busy, cfg_error, cfg_ready, load_mode} !== 4'b1000) begin
      n_fail++;
      $display("FAIL no_timeout: got busy/err/rdy/lm=%b expected 1000",
               {busy, cfg_error, cfg_ready, load_mode});
    end
    params_ready_in = 1'b1;
    tick();
    n_checks++;
    if ({busy, cfg_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL late_ready: got busy/rdy=%b expected 01", {busy, cfg_ready});
    end
`endif
  endtask

  task automatic test_reset_mid_shift();
    logic exp;
    send_frame(26'h1B7_E429);
    for (int k = 0; k < 10; k++) begin
      exp = exp_bit_q.pop_front();
      n_checks++;
      if (serial_data !== exp) begin
        n_fail++;
        $display("FAIL partial_bit[%0d]: got %b expected %b", k, serial_data, exp);
      end
      tick();
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({load_mode, busy, cfg_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL async_reset: got lm/busy/rdy=%b expected 000",
               {load_mode, busy, cfg_ready});
    end
    exp_bit_q.delete();
    params_ready_in = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    tick();
    n_checks++;
    if ({cfg_ready, busy, load_mode} !== 3'b100) begin
      n_fail++;
      $display("FAIL idle_after_reset: got rdy/busy/lm=%b expected 100",
               {cfg_ready, busy, load_mode});
    end
    send_frame(26'h1B7_E429);
    check_shift(1'b1);
    loader_to_run();
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_run_toggle();
    test_stuck_ready();
    test_timeout();
    test_reset_mid_shift();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lif_param_sequencer.md
# lif_param_sequencer

Configuration and run-control sequencer for the dual-channel LIF neuron system. Accepts a 26-bit parameter frame from the host over a valid/ready handshake and serialises it onto the system's `load_mode`/`serial_data` configuration pins. It then waits for the loader's `params_ready` before gating neuron operation through `input_enable`. The block sits between the host/control logic and the neuron system top level.

## Interface

**Parameters**

- `FRAME_W`, 26: frame length in bits; {weight_a[2:0], weight_b[2:0], leak_rate[7:0], threshold[7:0], leak_cycles[3:0]}.
- `TIMEOUT_CYC`, 64: maximum WAIT_RDY cycles before an error. Used only with the timeout macro.

**Ports**

- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cfg_valid`  in  1  host frame valid.
- `cfg_ready`  out  1  sequencer can accept a frame.
- `cfg_data`  in  FRAME_W  parameter frame, MSB first.
- `run_req`  in  1  host request to run the neuron.
- `params_ready_in`  in  1  from the system's `params_ready`.
- `load_mode`  out  1  to the system's `load_mode`.
- `serial_data`  out  1  to the system's `serial_data`.
- `input_enable`  out  1  to the system's `input_enable`.
- `busy`  out  1  high in SHIFT or WAIT_RDY.
- `cfg_error`  out  1  sticky load-timeout flag.

## Operation

**States:** IDLE, SHIFT, WAIT_RDY, RUN, plus ERROR when the timeout macro is compiled in.

**IDLE**
- `cfg_ready`=1.
- On `cfg_valid & cfg_ready`: latch `cfg_data` into the shift register, clear the bit counter, clear `seen_low`, go to SHIFT.

**SHIFT**
- `cfg_ready`=0, `load_mode`=1, `serial_data`=shift register MSB.
- The register shifts left each cycle.
- After the bit counter reaches FRAME_W-1, go to WAIT_RDY.
- `load_mode` is high for exactly FRAME_W cycles.

**WAIT_RDY**
- `load_mode`=0, `serial_data`=0.
- The loader drops `params_ready` while `load_mode` is high. As a guard against a stale high, `seen_low` is set whenever `params_ready_in`=0 is sampled in SHIFT or WAIT_RDY.
- Go to RUN when `params_ready_in`=1 and `seen_low`=1.

**RUN**
- `cfg_ready`=1.
- `input_enable` is registered: `input_enable` <= `run_req`.
- An accepted frame restarts SHIFT, and `input_enable` drops on that same edge.
- If `cfg_valid` and `run_req` arrive simultaneously, the frame wins.

**Outside RUN:** `input_enable`=0.

**Handshake rules**
- `cfg_valid` is ignored while `cfg_ready`=0.
- The frame is sampled only on the accept edge.

**Counters**
- The bit counter is ceil(log2(FRAME_W)) bits wide.
- The timeout counter saturates; it never wraps.

## Timing

- Reset values: `cfg_ready`=0 during reset and 1 at the first edge after release; `load_mode`, `serial_data`, `input_enable`, `busy`, `cfg_error` all 0; state IDLE.
- Accept at edge N: `load_mode`=1 and `serial_data`=`cfg_data`[FRAME_W-1] from edge N until edge N+FRAME_W. Bit k (from MSB) is driven during cycle N+k.
- WAIT_RDY starts at edge N+FRAME_W.
- If `params_ready_in` rises (with `seen_low` set) in cycle M, RUN is entered at edge M+1. `input_enable` follows `run_req` one cycle later.
- Reset asserted mid-SHIFT: `load_mode` drops immediately (asynchronously). The partial frame is discarded and the host must resend.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration

Macro: `LIF_SEQ_TIMEOUT_EN`.

**Defined:**
- WAIT_RDY counts cycles. Reaching TIMEOUT_CYC without qualified ready goes to ERROR.
- ERROR: `cfg_error`=1, `cfg_ready`=1, `input_enable`=0.
- An accepted frame clears `cfg_error` and enters SHIFT.

**Undefined:**
- No timeout counter and no ERROR state.
- WAIT_RDY waits indefinitely.
- `cfg_error` is tied to 0.

## Test plan

- Reset low then high, `cfg_valid`=0 -> all outputs 0; `cfg_ready`=1 one cycle after release.
- Frame 26'h2A5_C3F1, loader model raises ready 3 cycles after `load_mode` falls -> 26 serial bits MSB-first match the frame; `load_mode` high exactly 26 cycles; RUN 1 cycle after ready.
- RUN with `run_req` toggling 1,1,0,1 -> `input_enable` shows the same pattern delayed one cycle; frame plus `run_req` on the same cycle -> `input_enable`=0 next cycle and SHIFT restarts.
- `params_ready_in` held stuck high through the load -> no RUN until it is seen low then high.
- With `LIF_SEQ_TIMEOUT_EN` and `TIMEOUT_CYC`=64, ready never returns -> `cfg_error`=1 after 64 WAIT_RDY cycles; next frame clears it. Without the macro -> remains in WAIT_RDY with `cfg_error`=0.
- Reset at bit 10 of SHIFT -> `load_mode`=0 asynchronously; IDLE after release; a full resend completes normally.
